ahb_rr_arbiter: RTL
===================

AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 SHALL have parameter MASTER_NUMBER, default 4: number of requesting masters, range 2..16.
REQ-002 SHALL have parameter MIDX_W, default 2: width of the master index, equal to ceil(log2(MASTER_NUMBER)).
REQ-003 SHALL have parameter DEFAULT_MASTER, default 0: the master parked on the bus when there are no requests.
REQ-004 SHALL have port HCLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port HRESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port HBUSREQ, input, MASTER_NUMBER bits: per-master bus request.
REQ-007 SHALL have port HTRANS, input, 2 bits: transfer type of the address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 SHALL have port HBURST, input, 3 bits: burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
REQ-009 SHALL have port HREADY, input, 1 bit: the bus-wide transfer-done signal.
REQ-010 SHALL have port HGRANT, output, MASTER_NUMBER bits: registered, one-hot grant.
REQ-011 SHALL have port HMASTER, output, MIDX_W bits: registered index of the address-phase owner.

Function
REQ-012 SHALL have exactly one HGRANT bit high in every cycle after reset.
REQ-013 SHALL let HGRANT change only on a rising edge where HREADY=1.
REQ-014 SHALL load HMASTER with the index of the currently granted master on each HREADY=1 edge, so HMASTER lags HGRANT by one accepted transfer.
REQ-015 SHALL use states ARB and BURST_LOCK.
REQ-016 SHALL, in ARB, re-arbitrate on every HREADY=1 edge unless HTRANS=BUSY; with HTRANS=BUSY the current grant is held.
REQ-017 SHALL arbitrate round-robin: search starts at index (last_owner+1) mod MASTER_NUMBER and the first requester found wins.
REQ-018 SHALL keep the grant on the current owner if no other master requests and the owner still requests.
REQ-019 SHALL grant DEFAULT_MASTER when no HBUSREQ bit is set; parking does not update last_owner.
REQ-020 SHALL treat SINGLE and INCR as undefined length, arbitrated per REQ-016 with no lock.
REQ-021 SHALL transition ARB -> BURST_LOCK when HREADY=1 and HTRANS=NONSEQ with a fixed burst; the beat counter loads burst length minus 1 (3 for WRAP4/INCR4, 7 for WRAP8/INCR8, 15 for WRAP16/INCR16).
REQ-022 SHALL, in BURST_LOCK, hold HGRANT constant.
REQ-023 SHALL decrement the counter on each HREADY=1 edge with HTRANS=SEQ; BUSY beats do not count.
REQ-024 SHALL, when HREADY=1 and HTRANS=SEQ with counter=1, arbitrate and return to ARB, so the new grant is visible during the last beat's address phase.
REQ-025 SHALL treat early termination as follows: HTRANS=IDLE or NONSEQ while in BURST_LOCK with HREADY=1 clears the counter; IDLE returns to ARB and arbitrates, NONSEQ with a fixed burst reloads the counter per REQ-021.
REQ-026 SHALL hold all state unchanged while HREADY=0, including the counter, state, HGRANT and HMASTER.
REQ-027 SHALL ignore owner deassertion of HBUSREQ while in BURST_LOCK; the grant is held until REQ-024 or REQ-025 applies.
REQ-028 SHALL use a 4-bit counter with no wrap; it never decrements below 0.

Reset
REQ-029 SHALL, while HRESET=1 at a rising edge, set HGRANT to one-hot of DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, state=ARB, counter=0, and last_owner=MASTER_NUMBER-1 (so master 0 is searched first).
REQ-030 SHALL have reset override all other inputs, including reset asserted mid-burst, which aborts the lock immediately.

Verification
REQ-031 Reset: HBUSREQ=4'b1111 during reset -> HGRANT=4'b0001, HMASTER=0; first HREADY=1 edge after release -> HGRANT=4'b0001 (master 0 first).
REQ-032 Round-robin: HBUSREQ=4'b1111, HTRANS=NONSEQ, HBURST=SINGLE, HREADY=1 -> grant sequence 0,1,2,3,0 on successive edges; HMASTER trails by one edge.
REQ-033 INCR8 lock: master 1 starts INCR8 with HBUSREQ=4'b1111 -> HGRANT=4'b0010 held through 7 SEQ beats; after the 7th SEQ edge -> HGRANT=4'b0100.
REQ-034 Wait states and BUSY: INCR4 with HREADY=0 for 3 cycles and one BUSY beat inserted -> grant held; handover only after 3 SEQ HREADY=1 edges.
REQ-035 Early termination: WRAP16 interrupted after 5 beats by HTRANS=IDLE -> state ARB, counter=0, next requester granted on the same edge.
REQ-036 Park and mid-burst reset: HBUSREQ=0 -> HGRANT=4'b0001; HRESET=1 during INCR16 -> HGRANT=4'b0001 and counter=0 on the next edge.

Source files
------------

// File: rtl/ahb_rr_arbiter_if.sv
// ahb_rr_arbiter_if: request/grant signal bundle between the AHB masters and the arbiter
interface ahb_rr_arbiter_if #(
    parameter int MASTER_NUMBER = 4,
    parameter int MIDX_W = 2
);
    logic [MASTER_NUMBER-1:0] HBUSREQ;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic HREADY;
    logic [MASTER_NUMBER-1:0] HGRANT;
    logic [MIDX_W-1:0] HMASTER;
    modport slave (input HBUSREQ, HTRANS, HBURST, HREADY, output HGRANT, HMASTER);
    modport master (output HBUSREQ, HTRANS, HBURST, HREADY, input HGRANT, HMASTER);
endinterface

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: round-robin AHB bus arbiter with fixed-length burst locking
module ahb_rr_arbiter #(
    parameter int MASTER_NUMBER = 4,
    parameter int MIDX_W = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input logic HCLK,
    input logic HRESET,
    ahb_rr_arbiter_if.slave bus
);
    typedef enum logic {ARB, BURST_LOCK} state_t;
    localparam logic [1:0] T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d, blen;
    logic [MIDX_W-1:0] last_q, last_d, gidx_q, gidx_d, win, arb_idx;
    logic [MASTER_NUMBER-1:0] grant_q;
    logic [MIDX_W-1:0] hmaster_q;
    logic found, fixed, rearb;
    int idx;

    assign bus.HGRANT = grant_q;
    assign bus.HMASTER = hmaster_q;

    // round-robin search starting one past the last real owner; park on the default when idle
    always_comb begin
        found = 1'b0;
        win = last_q;
        idx = 0;
        for (int i = 1; i <= MASTER_NUMBER; i++) begin
            idx = (int'(last_q) + i) % MASTER_NUMBER;
            if (!found && bus.HBUSREQ[idx]) begin
                found = 1'b1;
                win = MIDX_W'(idx);
            end
        end
        arb_idx = found ? win : MIDX_W'(DEFAULT_MASTER);
    end

    // next state: lock on fixed bursts, release on the last SEQ beat or an early IDLE/NONSEQ
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        last_d = last_q;
        gidx_d = gidx_q;
        rearb = 1'b0;
        fixed = bus.HBURST[2] | bus.HBURST[1];
        blen = bus.HBURST[2] ? (bus.HBURST[1] ? 4'd15 : 4'd7) : 4'd3;
        if (bus.HREADY) begin
            if (state_q == ARB) begin
                if (bus.HTRANS == T_NONSEQ && fixed) begin
                    state_d = BURST_LOCK;
                    cnt_d = blen;
                end else if (bus.HTRANS != T_BUSY) begin
                    rearb = 1'b1;
                end
            end else if (bus.HTRANS == T_SEQ) begin
                if (cnt_q <= 4'd1) begin
                    rearb = 1'b1;
                    cnt_d = 4'd0;
                    state_d = ARB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end else if (bus.HTRANS == T_NONSEQ && fixed) begin
                cnt_d = blen;
            end else if (bus.HTRANS != T_BUSY) begin
                rearb = 1'b1;
                cnt_d = 4'd0;
                state_d = ARB;
            end
        end
        if (rearb) begin
            gidx_d = arb_idx;
            if (found) last_d = win;
        end
    end

    // state registers advance only on accepted transfers; reset wins over everything
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ARB;
            cnt_q <= 4'd0;
            last_q <= MIDX_W'(MASTER_NUMBER - 1);
            gidx_q <= MIDX_W'(DEFAULT_MASTER);
            grant_q <= MASTER_NUMBER'(1) << DEFAULT_MASTER;
            hmaster_q <= MIDX_W'(DEFAULT_MASTER);
        end else if (bus.HREADY) begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            last_q <= last_d;
            gidx_q <= gidx_d;
            grant_q <= MASTER_NUMBER'(1) << gidx_d;
            hmaster_q <= gidx_q;
        end
    end
endmodule
